// File: rtl/sweep_controller.sv
// sweep_controller
//
// Frequency-sweep sequencer for the phase-accumulator waveform generators.
// A sweep descriptor is taken over a valid/ready handshake, after which the
// generator step value is walked from cfg_start to cfg_stop, holding every
// value for a programmed number of cycles.
//
// Modes: 0 single-shot, 1 repeat (jump back to start), 2 ping-pong
// (bounce between the endpoints), 3 behaves as 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   cfg_valid  descriptor valid
//   cfg_ready  controller idle and able to accept a descriptor
//   cfg_start  first step value
//   cfg_stop   final step value (sweep endpoint)
//   cfg_incr   step increment magnitude (0 treated as 1)
//   cfg_dwell  cycles each value is held (0 treated as 1)
//   cfg_mode   sweep mode
//   abort      terminate an active sweep (ignored when idle)
//   step_out   drives the generator step input
//   gen_reset  one-cycle pulse clearing the generator phase accumulator
//   busy       sweep in progress
//   done       one-cycle pulse on single-shot completion
//   seg_tick   one-cycle pulse at each endpoint restart/turnaround (modes 1, 2)

module sweep_controller #(
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [STEP_W-1:0]  cfg_start,
    input  logic [STEP_W-1:0]  cfg_stop,
    input  logic [STEP_W-1:0]  cfg_incr,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               abort,
    output logic [STEP_W-1:0]  step_out,
    output logic               gen_reset,
    output logic               busy,
    output logic               done,
    output logic               seg_tick
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModeRepeat   = 2'd1;
    localparam logic [1:0] ModePingPong = 2'd2;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   target_q, target_d;
    logic [STEP_W-1:0]   origin_q, origin_d;
    logic [STEP_W-1:0]   incr_q, incr_d;
    logic [DWELL_W-1:0]  dwell_eff_q, dwell_eff_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                dir_up_q, dir_up_d;
    logic [1:0]          mode_q, mode_d;
    logic                gen_reset_q, gen_reset_d;
    logic                done_q, done_d;
    logic                seg_tick_q, seg_tick_d;

    logic                dwell_last;

    // One increment from cur toward tgt, clamped to tgt. The sum/difference
    // is formed one bit wider so a carry or borrow also clamps instead of
    // wrapping around the step range.
    function automatic logic [STEP_W-1:0] advance(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] tgt,
        input logic [STEP_W-1:0] inc,
        input logic              up
    );
        logic [STEP_W:0] sum;
        logic [STEP_W:0] diff;
        logic [STEP_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        if (up) begin
            res = (sum[STEP_W] || (sum[STEP_W-1:0] >= tgt)) ? tgt : sum[STEP_W-1:0];
        end else begin
            res = (diff[STEP_W] || (diff[STEP_W-1:0] <= tgt)) ? tgt : diff[STEP_W-1:0];
        end
        return res;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            step_q      <= '0;
            target_q    <= '0;
            origin_q    <= '0;
            incr_q      <= '0;
            dwell_eff_q <= '0;
            dwell_cnt_q <= '0;
            dir_up_q    <= 1'b0;
            mode_q      <= 2'd0;
            gen_reset_q <= 1'b0;
            done_q      <= 1'b0;
            seg_tick_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            target_q    <= target_d;
            origin_q    <= origin_d;
            incr_q      <= incr_d;
            dwell_eff_q <= dwell_eff_d;
            dwell_cnt_q <= dwell_cnt_d;
            dir_up_q    <= dir_up_d;
            mode_q      <= mode_d;
            gen_reset_q <= gen_reset_d;
            done_q      <= done_d;
            seg_tick_q  <= seg_tick_d;
        end
    end

    assign dwell_last = (dwell_cnt_q == (dwell_eff_q - DWELL_W'(1)));

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        target_d    = target_q;
        origin_d    = origin_q;
        incr_d      = incr_q;
        dwell_eff_d = dwell_eff_q;
        dwell_cnt_d = dwell_cnt_q;
        dir_up_d    = dir_up_q;
        mode_d      = mode_q;
        // Pulses are low unless explicitly raised for one cycle
        gen_reset_d = 1'b0;
        done_d      = 1'b0;
        seg_tick_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    state_d     = StRun;
                    step_d      = cfg_start;
                    target_d    = cfg_stop;
                    origin_d    = cfg_start;
                    incr_d      = (cfg_incr == '0) ? STEP_W'(1) : cfg_incr;
                    dwell_eff_d = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                    dwell_cnt_d = '0;
                    dir_up_d    = (cfg_stop >= cfg_start);
                    mode_d      = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
                    gen_reset_d = 1'b1;
                end
            end

            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    step_d      = '0;
                    dwell_cnt_d = '0;
                end else if (!dwell_last) begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end else if (step_q != target_q) begin
                    step_d      = advance(step_q, target_q, incr_q, dir_up_q);
                    dwell_cnt_d = '0;
                end else begin
                    // Endpoint dwell complete
                    dwell_cnt_d = '0;
                    case (mode_q)
                        ModeRepeat: begin
                            step_d      = origin_q;
                            seg_tick_d  = 1'b1;
                            gen_reset_d = 1'b1;
                        end
                        ModePingPong: begin
                            // Turn around and move straight off the endpoint
                            // so its value is not held twice.
                            target_d   = origin_q;
                            origin_d   = target_q;
                            dir_up_d   = !dir_up_q;
                            step_d     = advance(step_q, origin_q, incr_q, !dir_up_q);
                            seg_tick_d = 1'b1;
                        end
                        default: begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        cfg_ready = (state_q == StIdle);
        busy      = (state_q == StRun);
        step_out  = step_q;
        gen_reset = gen_reset_q;
        done      = done_q;
        seg_tick  = seg_tick_q;
    end

endmodule
